// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access
//  Description : MEM-stage data memory access unit. Issues a single registered
//                bus transaction per load/store, stalls the front of the pipe
//                until it completes, aligns load data and replicates store
//                data across byte lanes, and flags address-error exceptions.
//  Ports       : clk/reset           - clock, synchronous active-high reset
//                in_valid, MemRead, MemWrite, mem_size, mem_sign, Aluout,
//                wdata, flush        - request from the EX/MEM register
//                rd, RegWrite, MemtoReg, pc, mfc0, except_data
//                                    - WB-bound sideband
//                data_*              - memory bus (req/wr/addr/wstrb/wdata out,
//                                      rdata/ack in)
//                mem_stall           - freezes PC/IF/ID/EX and EX/MEM
//                *_out               - feed the MEM/WB register
//                exc_adel, exc_ades, badvaddr - address-error reporting
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  mem_size,
    input  logic        mem_sign,
    input  logic [31:0] Aluout,
    input  logic [31:0] wdata,
    input  logic        flush,
    input  logic [4:0]  rd,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic [31:0] pc,
    input  logic        mfc0,
    input  logic [31:0] except_data,
    output logic        data_req,
    output logic        data_wr,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic [31:0] data_rdata,
    input  logic        data_ack,
    output logic        mem_stall,
    output logic        MemtoReg_out,
    output logic        RegWrite_out,
    output logic [31:0] Aluout_out,
    output logic [31:0] pc_out,
    output logic [31:0] rdata_out,
    output logic [4:0]  rd_out,
    output logic        mfc0_out,
    output logic [31:0] except_data_out,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic [31:0] badvaddr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        data_req_q, data_req_d;
    logic        data_wr_q, data_wr_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [3:0]  data_wstrb_q, data_wstrb_d;
    logic [31:0] data_wdata_q, data_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic        flushed_q, flushed_d;

    logic        is_byte, is_half;
    logic        mem_op, misaligned, start, exc;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] ld_value;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Size code 11 falls through to word handling everywhere.
    assign is_byte    = (mem_size == 2'b00);
    assign is_half    = (mem_size == 2'b01);
    assign mem_op     = in_valid & (MemRead | MemWrite) & ~flush;
    assign misaligned = (is_half & Aluout[0]) | (~is_byte & ~is_half & (|Aluout[1:0]));
    assign start      = (state_q == S_IDLE) & mem_op & ~misaligned;
    // Gated by mem_op, so a flush always suppresses the exception.
    assign exc        = (state_q == S_IDLE) & mem_op & misaligned;

    // Store lane enables and lane-replicated data.
    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = wdata;
        if (is_byte) begin
            st_wstrb = 4'b0001 << Aluout[1:0];
            st_wdata = {4{wdata[7:0]}};
        end else if (is_half) begin
            st_wstrb = 4'b0011 << {Aluout[1], 1'b0};
            st_wdata = {2{wdata[15:0]}};
        end
    end

    // Load alignment uses the request attributes captured at issue time.
    always_comb begin
        ld_byte  = data_rdata[8*addr_lo_q +: 8];
        ld_half  = addr_lo_q[1] ? data_rdata[31:16] : data_rdata[15:0];
        ld_value = data_rdata;
        if (size_q == 2'b00)
            ld_value = {{24{sign_q & ld_byte[7]}}, ld_byte};
        else if (size_q == 2'b01)
            ld_value = {{16{sign_q & ld_half[15]}}, ld_half};
    end

    always_comb begin
        state_d      = state_q;
        data_req_d   = data_req_q;
        data_wr_d    = data_wr_q;
        data_addr_d  = data_addr_q;
        data_wstrb_d = data_wstrb_q;
        data_wdata_d = data_wdata_q;
        rdata_d      = rdata_q;
        addr_lo_d    = addr_lo_q;
        size_d       = size_q;
        sign_d       = sign_q;
        flushed_d    = flushed_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_BUS;
                    data_req_d   = 1'b1;
                    data_wr_d    = MemWrite;
                    data_addr_d  = {Aluout[31:2], 2'b00};
                    data_wstrb_d = MemWrite ? st_wstrb : 4'b0000;
                    data_wdata_d = st_wdata;
                    addr_lo_d    = Aluout[1:0];
                    size_d       = mem_size;
                    sign_d       = mem_sign;
                    flushed_d    = 1'b0;
                    // Cleared here so a store's DONE cycle never exposes a
                    // stale load value.
                    rdata_d      = 32'h0;
                end
            end
            S_BUS: begin
                // A flush mid-transaction lets the bus cycle finish but
                // marks the result for discard.
                if (flush)
                    flushed_d = 1'b1;
                if (data_ack) begin
                    state_d    = S_DONE;
                    data_req_d = 1'b0;
                    if (!data_wr_q)
                        rdata_d = ld_value;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            data_req_q   <= 1'b0;
            data_wr_q    <= 1'b0;
            data_addr_q  <= 32'h0;
            data_wstrb_q <= 4'h0;
            data_wdata_q <= 32'h0;
            rdata_q      <= 32'h0;
            addr_lo_q    <= 2'b00;
            size_q       <= 2'b00;
            sign_q       <= 1'b0;
            flushed_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_req_q   <= data_req_d;
            data_wr_q    <= data_wr_d;
            data_addr_q  <= data_addr_d;
            data_wstrb_q <= data_wstrb_d;
            data_wdata_q <= data_wdata_d;
            rdata_q      <= rdata_d;
            addr_lo_q    <= addr_lo_d;
            size_q       <= size_d;
            sign_q       <= sign_d;
            flushed_q    <= flushed_d;
        end
    end

    assign data_req   = data_req_q;
    assign data_wr    = data_wr_q;
    assign data_addr  = data_addr_q;
    assign data_wstrb = data_wstrb_q;
    assign data_wdata = data_wdata_q;

    assign mem_stall  = start | (state_q == S_BUS);

    assign exc_adel   = exc & MemRead;
    assign exc_ades   = exc & MemWrite & ~MemRead;
    assign badvaddr   = exc ? Aluout : 32'h0;

    // EX/MEM is frozen during the access, so sideband passes straight through.
    assign MemtoReg_out    = MemtoReg;
    assign Aluout_out      = Aluout;
    assign pc_out          = pc;
    assign rd_out          = rd;
    assign mfc0_out        = mfc0;
    assign except_data_out = except_data;
    assign RegWrite_out    = RegWrite & ~flush & ~exc & ~((state_q == S_DONE) & flushed_q);
    assign rdata_out       = (state_q == S_DONE) ? rdata_q : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access
//  Description : Directed self-checking bench for mem_access.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
    logic [1:0]  mem_size = 2'b10;
    logic        mem_sign = 1'b0;
    logic [31:0] Aluout = 32'h0, wdata = 32'h0;
    logic        flush = 1'b0;
    logic [4:0]  rd = 5'd0;
    logic        RegWrite = 1'b0, MemtoReg = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        mfc0 = 1'b0;
    logic [31:0] except_data = 32'h0;
    logic        data_req, data_wr;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic [31:0] data_rdata = 32'h0;
    logic        data_ack = 1'b0;
    logic        mem_stall, MemtoReg_out, RegWrite_out, mfc0_out;
    logic [31:0] Aluout_out, pc_out, rdata_out, except_data_out, badvaddr;
    logic [4:0]  rd_out;
    logic        exc_adel, exc_ades;

    int n_cmp = 0;
    int n_err = 0;

    logic        bus_req, bus_wr;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;

    mem_access dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .MemRead(MemRead),
        .MemWrite(MemWrite), .mem_size(mem_size), .mem_sign(mem_sign),
        .Aluout(Aluout), .wdata(wdata), .flush(flush), .rd(rd),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .pc(pc), .mfc0(mfc0),
        .except_data(except_data), .data_req(data_req), .data_wr(data_wr),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_ack(data_ack), .mem_stall(mem_stall),
        .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
        .Aluout_out(Aluout_out), .pc_out(pc_out), .rdata_out(rdata_out),
        .rd_out(rd_out), .mfc0_out(mfc0_out), .except_data_out(except_data_out),
        .exc_adel(exc_adel), .exc_ades(exc_ades), .badvaddr(badvaddr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        flush = 1'b0; data_ack = 1'b0; data_rdata = 32'h0;
    endtask

    task automatic set_op(input logic rd_en, input logic wr_en, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd);
        in_valid = 1'b1; MemRead = rd_en; MemWrite = wr_en;
        mem_size = sz; mem_sign = sg; Aluout = a; wdata = wd;
        RegWrite = rd_en; MemtoReg = rd_en;
    endtask

    // Same-cycle ack: IDLE -> BUS -> DONE; returns at DONE with bus values seen in BUS.
    task automatic mem_op(input logic rd_en, input logic wr_en, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat);
        set_op(rd_en, wr_en, sz, sg, a, wd);
        tick();
        bus_req = data_req; bus_wr = data_wr; bus_addr = data_addr;
        bus_wstrb = data_wstrb; bus_wdata = data_wdata;
        data_ack = 1'b1; data_rdata = rdat;
        tick();
        data_ack = 1'b0; data_rdata = 32'h0;
        #1;
    endtask

    initial begin
        // ---- reset state
        tick(); tick();
        chk("rst_req",   {31'b0, data_req}, 32'h0);
        chk("rst_wr",    {31'b0, data_wr}, 32'h0);
        chk("rst_addr",  data_addr, 32'h0);
        chk("rst_wstrb", {28'b0, data_wstrb}, 32'h0);
        chk("rst_wdata", data_wdata, 32'h0);
        chk("rst_stall", {31'b0, mem_stall}, 32'h0);
        chk("rst_exc",   {30'b0, exc_adel, exc_ades}, 32'h0);
        chk("rst_bva",   badvaddr, 32'h0);
        reset = 1'b0;
        tick();

        // ---- LW 0x100, ack two cycles after request
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        rd = 5'd7;
        #1;
        chk("lw_idle_stall", {31'b0, mem_stall}, 32'h1);
        chk("lw_idle_req",   {31'b0, data_req}, 32'h0);
        tick();
        chk("lw_bus_req",   {31'b0, data_req}, 32'h1);
        chk("lw_bus_addr",  data_addr, 32'h100);
        chk("lw_bus_wstrb", {28'b0, data_wstrb}, 32'h0);
        chk("lw_bus_wr",    {31'b0, data_wr}, 32'h0);
        chk("lw_bus_stall", {31'b0, mem_stall}, 32'h1);
        tick();
        chk("lw_hold_req",   {31'b0, data_req}, 32'h1);
        chk("lw_hold_stall", {31'b0, mem_stall}, 32'h1);
        tick();
        data_ack = 1'b1; data_rdata = 32'hDEADBEEF;
        #1;
        chk("lw_ack_stall", {31'b0, mem_stall}, 32'h1);
        tick();
        data_ack = 1'b0; data_rdata = 32'h0;
        #1;
        chk("lw_done_stall", {31'b0, mem_stall}, 32'h0);
        chk("lw_done_req",   {31'b0, data_req}, 32'h0);
        chk("lw_done_rdata", rdata_out, 32'hDEADBEEF);
        chk("lw_done_rw",    {31'b0, RegWrite_out}, 32'h1);
        chk("lw_done_rd",    {27'b0, rd_out}, 32'd7);
        clear_in();
        tick();
        chk("lw_after_rdata", rdata_out, 32'h0);

        // ---- load extraction
        mem_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80112233);
        chk("lb_rdata", rdata_out, 32'hFFFFFF80);
        chk("lb_addr",  bus_addr, 32'h100);
        clear_in(); tick();
        mem_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80112233);
        chk("lbu_rdata", rdata_out, 32'h00000080);
        clear_in(); tick();
        mem_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h80112233);
        chk("lh_rdata", rdata_out, 32'hFFFF8011);
        clear_in(); tick();
        mem_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'h80119233);
        chk("lhu_rdata", rdata_out, 32'h00009233);
        clear_in(); tick();

        // ---- stores
        mem_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h201, 32'h000000AB, 32'hFFFFFFFF);
        chk("sb_req",   {31'b0, bus_req}, 32'h1);
        chk("sb_wr",    {31'b0, bus_wr}, 32'h1);
        chk("sb_addr",  bus_addr, 32'h200);
        chk("sb_wstrb", {28'b0, bus_wstrb}, 32'h2);
        chk("sb_wdata", bus_wdata, 32'hABABABAB);
        chk("sb_rdata", rdata_out, 32'h0);
        clear_in(); tick();
        mem_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h1234CDEF, 32'h0);
        chk("sh_wstrb", {28'b0, bus_wstrb}, 32'hC);
        chk("sh_wdata", bus_wdata, 32'hCDEFCDEF);
        clear_in(); tick();
        mem_op(1'b0, 1'b1, 2'b11, 1'b0, 32'h300, 32'h11223344, 32'h0);
        chk("sw_wstrb", {28'b0, bus_wstrb}, 32'hF);
        chk("sw_wdata", bus_wdata, 32'h11223344);
        clear_in(); tick();

        // ---- misaligned
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
        #1;
        chk("adel_flag",  {31'b0, exc_adel}, 32'h1);
        chk("adel_ades",  {31'b0, exc_ades}, 32'h0);
        chk("adel_bva",   badvaddr, 32'h102);
        chk("adel_stall", {31'b0, mem_stall}, 32'h0);
        chk("adel_rw",    {31'b0, RegWrite_out}, 32'h0);
        tick();
        chk("adel_noreq", {31'b0, data_req}, 32'h0);
        set_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h101, 32'h0);
        #1;
        chk("ades_flag", {31'b0, exc_ades}, 32'h1);
        chk("ades_bva",  badvaddr, 32'h101);
        // flush beats misalignment
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
        flush = 1'b1;
        #1;
        chk("flmis_exc",   {30'b0, exc_adel, exc_ades}, 32'h0);
        chk("flmis_stall", {31'b0, mem_stall}, 32'h0);
        chk("flmis_rw",    {31'b0, RegWrite_out}, 32'h0);
        tick();
        chk("flmis_noreq", {31'b0, data_req}, 32'h0);
        clear_in(); tick();

        // ---- non-memory pass-through
        in_valid = 1'b1; RegWrite = 1'b1; MemtoReg = 1'b0; Aluout = 32'h1234;
        pc = 32'hBFC00010; rd = 5'd9; mfc0 = 1'b1; except_data = 32'hCAFE0001;
        #1;
        chk("nm_stall", {31'b0, mem_stall}, 32'h0);
        chk("nm_alu",   Aluout_out, 32'h1234);
        chk("nm_pc",    pc_out, 32'hBFC00010);
        chk("nm_rd",    {27'b0, rd_out}, 32'd9);
        chk("nm_mfc0",  {31'b0, mfc0_out}, 32'h1);
        chk("nm_exd",   except_data_out, 32'hCAFE0001);
        chk("nm_rw",    {31'b0, RegWrite_out}, 32'h1);
        chk("nm_rdata", rdata_out, 32'h0);
        tick();
        chk("nm_noreq", {31'b0, data_req}, 32'h0);
        clear_in(); mfc0 = 1'b0; tick();

        // ---- flush during BUS: transaction completes, result discarded
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        tick();
        flush = 1'b1;
        #1;
        chk("flbus_req1", {31'b0, data_req}, 32'h1);
        tick();
        flush = 1'b0;
        #1;
        chk("flbus_req2", {31'b0, data_req}, 32'h1);
        chk("flbus_addr", data_addr, 32'h100);
        tick();
        chk("flbus_req3", {31'b0, data_req}, 32'h1);
        tick();
        data_ack = 1'b1; data_rdata = 32'h55555555;
        #1;
        chk("flbus_req4", {31'b0, data_req}, 32'h1);
        tick();
        data_ack = 1'b0;
        #1;
        chk("flbus_done_stall", {31'b0, mem_stall}, 32'h0);
        chk("flbus_done_rw",    {31'b0, RegWrite_out}, 32'h0);
        chk("flbus_done_req",   {31'b0, data_req}, 32'h0);
        clear_in(); tick();

        // ---- reset while in BUS; late ack ignored
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        tick();
        chk("rbus_req", {31'b0, data_req}, 32'h1);
        reset = 1'b1;
        tick();
        clear_in();
        #1;
        chk("rbus_req_drop", {31'b0, data_req}, 32'h0);
        chk("rbus_stall",    {31'b0, mem_stall}, 32'h0);
        chk("rbus_addr",     data_addr, 32'h0);
        reset = 1'b0;
        data_ack = 1'b1; data_rdata = 32'h12345678;
        tick();
        data_ack = 1'b0;
        #1;
        chk("late_ack_req",   {31'b0, data_req}, 32'h0);
        chk("late_ack_stall", {31'b0, mem_stall}, 32'h0);
        chk("late_ack_rdata", rdata_out, 32'h0);
        mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'h0BADF00D);
        chk("post_rst_rdata", rdata_out, 32'h0BADF00D);
        chk("post_rst_addr",  bus_addr, 32'h104);
        clear_in(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
